car_motion_ctrl: RTL and testbench

Car motion controller; sits directly downstream of the elevator direction decider. Consumes the decider's direction bit plus the pending-request bitmap, moves the car one floor per FLOOR_TICKS cycles, stops and opens the door at requested floors, and reports each served floor so the request logic can clear it. Its cur_floor output is the floor position fed back to the direction decider.

---
 rtl/elevator_pkg.sv | 32 +++
 rtl/tick_timer.sv | 28 ++
 rtl/car_motion_ctrl.sv | 123 ++++++++++++
 tb/tb_car_motion_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions used by the direction decider, request register and motion controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 20;
    localparam int FLOOR_W    = 5;
    localparam int MAX_FLOORS = 1 << FLOOR_W;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_e;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Bit i of req is floor i+1; true when any request lies strictly beyond floor in dir.
    function automatic logic req_ahead(input logic [MAX_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    floor,
                                       input logic                  dir);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (req[i]) begin
                if (dir == UP && i >= int'(floor))       hit = 1'b1;
                if (dir == DOWN && (i + 2) <= int'(floor)) hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Cycle counter with synchronous clear, count enable and a terminal-count flag at a selectable value.
module tick_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)     count_d = '0;
        else if (en_i) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign tc_o = (count_q == last_i);

endmodule

// File: rtl/car_motion_ctrl.sv
// Elevator car motion controller: moves one floor per FLOOR_TICKS cycles, dwells DOOR_TICKS cycles
// at served floors and pulses served_valid when the door opens.
module car_motion_ctrl #(
    parameter int NUM_FLOORS  = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             dir_up,
    input  logic [NUM_FLOORS-1:0]            req,
    output logic [elevator_pkg::FLOOR_W-1:0] cur_floor,
    output logic                             moving,
    output logic                             door_open,
    output logic                             served_valid,
    output logic [elevator_pkg::FLOOR_W-1:0] served_floor
);
    import elevator_pkg::*;

    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TIMER_W   = $clog2(MAX_TICKS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS);
    localparam logic [TIMER_W-1:0] FLOOR_LAST = TIMER_W'(FLOOR_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST  = TIMER_W'(DOOR_TICKS - 1);

    state_e               state_q, state_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 dir_q, dir_d;
    logic                 moving_q, door_q, served_vld_q;
    logic [FLOOR_W-1:0]   served_floor_q;
    logic                 tmr_clr, tmr_en, tmr_tc;
    logic [TIMER_W-1:0]   tmr_last;
    logic [MAX_FLOORS-1:0] req_w;
    logic [FLOOR_W-1:0]   next_floor;
    logic                 at_end;

    assign req_w = MAX_FLOORS'(req);

    tick_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .last_i (tmr_last),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_last   = (state_q == DOOR) ? DOOR_LAST : FLOOR_LAST;
        next_floor = (dir_q == UP) ? floor_q + 1'b1 : floor_q - 1'b1;
        at_end     = (dir_q == UP) ? (floor_q == TOP_FLOOR) : (floor_q == FLOOR_W'(1));
        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (req_w[floor_q - 1'b1]) begin
                    state_d = DOOR;
                end else if (|req) begin
                    state_d = MOVE;
                    if (floor_q == TOP_FLOOR)        dir_d = DOWN;
                    else if (floor_q == FLOOR_W'(1)) dir_d = UP;
                    else                             dir_d = dir_up;
                end
            end
            MOVE: begin
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    // A step past either end of the shaft parks the car instead.
                    if (at_end) begin
                        state_d = IDLE;
                    end else begin
                        floor_d = next_floor;
                        if (req_w[next_floor - 1'b1])              state_d = DOOR;
                        else if (req_ahead(req_w, next_floor, dir_q)) state_d = MOVE;
                        else                                       state_d = IDLE;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DOOR: begin
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            floor_q        <= FLOOR_W'(1);
            dir_q          <= UP;
            moving_q       <= 1'b0;
            door_q         <= 1'b0;
            served_vld_q   <= 1'b0;
            served_floor_q <= '0;
        end else begin
            state_q        <= state_d;
            floor_q        <= floor_d;
            dir_q          <= dir_d;
            moving_q       <= (state_d == MOVE);
            door_q         <= (state_d == DOOR);
            served_vld_q   <= (state_d == DOOR) && (state_q != DOOR);
            served_floor_q <= ((state_d == DOOR) && (state_q != DOOR)) ? floor_d : '0;
        end
    end

    assign cur_floor    = floor_q;
    assign moving       = moving_q;
    assign door_open    = door_q;
    assign served_valid = served_vld_q;
    assign served_floor = served_floor_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Randomised and directed bench for car_motion_ctrl against a trip-level reference model.
module tb_car_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dir_up = 1'b0;
    logic [19:0] req = '0;
    logic [4:0]  cur_floor, served_floor;
    logic        moving, door_open, served_valid;

    int n_vec = 0;
    int n_err = 0;
    int m_floor = 1;

    car_motion_ctrl #(.NUM_FLOORS(20), .FLOOR_TICKS(8), .DOOR_TICKS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .dir_up       (dir_up),
        .req          (req),
        .cur_floor    (cur_floor),
        .moving       (moving),
        .door_open    (door_open),
        .served_valid (served_valid),
        .served_floor (served_floor)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One trip from idle: predict the stop floor and arrival edge from the request set,
    // then check every output on every edge until the car is idle again.
    task automatic run_leg(input logic [19:0] r, input logic d, input string tag);
        int c, dd, k, edges, ef;
        bit door, found;
        logic [12:0] got, exp_v;
        c = m_floor;
        dd = 0; k = c; edges = 1; door = 0; found = 0;
        req = r;
        dir_up = d;
        if (r[c-1]) begin
            door = 1;
        end else if (r != 0) begin
            dd = (c == 20) ? -1 : (c == 1) ? 1 : (d ? 1 : -1);
            for (int f = c + dd; f >= 1 && f <= 20; f += dd) begin
                if (!found && r[f-1]) begin
                    k = f;
                    found = 1;
                end
            end
            if (found) begin
                door = 1;
                edges = 1 + ((k > c) ? (k - c) : (c - k)) * 8;
            end else begin
                k = c + dd;
                edges = 9;
            end
        end
        for (int n = 1; n <= edges; n++) begin
            step();
            ef = (n == edges) ? k : c + dd * ((n - 1) / 8);
            exp_v = (n == edges) ? {5'(k), 1'b0, door, door, door ? 5'(k) : 5'd0}
                                 : {5'(ef), 1'b1, 1'b0, 1'b0, 5'd0};
            got = {cur_floor, moving, door_open, served_valid, served_floor};
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL %s edge %0d: floor/mov/door/sv/sf got %0d/%b/%b/%b/%0d need %0d/%b/%b/%b/%0d",
                         tag, n, cur_floor, moving, door_open, served_valid, served_floor,
                         exp_v[12:8], exp_v[7], exp_v[6], exp_v[5], exp_v[4:0]);
            end
        end
        if (door) begin
            req = r & ~(20'(1) << (k - 1));
            for (int j = 2; j <= 5; j++) begin
                step();
                exp_v = {5'(k), 1'b0, (j <= 4), 1'b0, 5'd0};
                got = {cur_floor, moving, door_open, served_valid, served_floor};
                n_vec++;
                if (got !== exp_v) begin
                    n_err++;
                    $display("FAIL %s door cycle %0d: floor/mov/door/sv/sf got %0d/%b/%b/%b/%0d need %0d/0/%b/0/0",
                             tag, j, cur_floor, moving, door_open, served_valid, served_floor,
                             k, (j <= 4));
                end
            end
        end
        m_floor = k;
    endtask

    task automatic go_to(input int k);
        if (m_floor != k) run_leg(20'(1) << (k - 1), (k > m_floor), "goto");
    endtask

    task automatic test_reset();
        req = '0;
        dir_up = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({cur_floor, moving, door_open, served_valid, served_floor} !== {5'd1, 3'b000, 5'd0}) begin
            n_err++;
            $display("FAIL reset_hold: floor=%0d mov=%b door=%b sv=%b sf=%0d need 1/0/0/0/0",
                     cur_floor, moving, door_open, served_valid, served_floor);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        n_vec++;
        if ({cur_floor, moving, door_open, served_valid, served_floor} !== {5'd1, 3'b000, 5'd0}) begin
            n_err++;
            $display("FAIL reset_release: floor=%0d mov=%b door=%b sv=%b sf=%0d need 1/0/0/0/0",
                     cur_floor, moving, door_open, served_valid, served_floor);
        end
        m_floor = 1;
    endtask

    task automatic test_same_floor();
        go_to(1);
        run_leg(20'h00001, 1'b0, "same_floor");
    endtask

    task automatic test_travel();
        go_to(1);
        run_leg(20'h00008, 1'b1, "travel_1_to_4");
    endtask

    task automatic test_intermediate_stop();
        go_to(1);
        run_leg(20'h00014, 1'b1, "stop_at_3");
        run_leg(20'h00010, 1'b1, "resume_to_5");
        n_vec++;
        if (cur_floor !== 5'd5) begin
            n_err++;
            $display("FAIL intermediate_final_floor: got %0d need 5", cur_floor);
        end
    endtask

    task automatic test_top_boundary();
        go_to(20);
        run_leg(20'h20000, 1'b1, "top_forced_down");
    endtask

    task automatic test_withdraw();
        logic [12:0] got, exp_v;
        int ef;
        go_to(1);
        req = 20'h00020;
        dir_up = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            step();
            if (n == 10) req = '0;
            ef = (n >= 17) ? 3 : 1 + (n - 1) / 8;
            exp_v = {5'(ef), (n < 17), 1'b0, 1'b0, 5'd0};
            got = {cur_floor, moving, door_open, served_valid, served_floor};
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL withdraw edge %0d: floor/mov/door/sv/sf got %0d/%b/%b/%b/%0d need %0d/%b/0/0/0",
                         n, cur_floor, moving, door_open, served_valid, served_floor, ef, (n < 17));
            end
        end
        m_floor = 3;
    endtask

    task automatic test_random();
        logic [19:0] r;
        for (int i = 0; i < 30; i++) begin
            r = 20'(1) << $urandom_range(0, 19);
            if ($urandom_range(0, 1) == 1) r = r | (20'(1) << $urandom_range(0, 19));
            if ($urandom_range(0, 7) == 0) r = '0;
            run_leg(r, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_async_reset();
        go_to(1);
        req = 20'h80000;
        dir_up = 1'b1;
        repeat (12) step();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({cur_floor, moving, door_open, served_valid, served_floor} !== {5'd1, 3'b000, 5'd0}) begin
            n_err++;
            $display("FAIL async_reset_move: floor=%0d mov=%b door=%b sv=%b sf=%0d need 1/0/0/0/0",
                     cur_floor, moving, door_open, served_valid, served_floor);
        end
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        m_floor = 1;
        req = 20'h00001;
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({cur_floor, moving, door_open, served_valid, served_floor} !== {5'd1, 3'b000, 5'd0}) begin
            n_err++;
            $display("FAIL async_reset_door: floor=%0d mov=%b door=%b sv=%b sf=%0d need 1/0/0/0/0",
                     cur_floor, moving, door_open, served_valid, served_floor);
        end
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        n_vec++;
        if ({moving, door_open, served_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset_idle: mov=%b door=%b sv=%b need 0/0/0", moving, door_open, served_valid);
        end
    endtask

    initial begin
        test_reset();
        test_same_floor();
        test_travel();
        test_intermediate_stop();
        test_top_boundary();
        test_withdraw();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
